// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong score controller.
package pingpong_pkg;

    localparam int SCORE_W = 7;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } wr_state_e;

    // True when 'mine' is at least win_pts and leads 'other' by at least margin.
    function automatic logic has_won(input logic [SCORE_W-1:0] mine,
                                     input logic [SCORE_W-1:0] other,
                                     input int win_pts,
                                     input int margin);
        return (int'(mine) >= win_pts) && ((int'(mine) - int'(other)) >= margin);
    endfunction

endpackage

// File: rtl/pingpong_score_enc.sv
// Score display encoder: plain binary, or two-digit BCD clipped at 79
// when SCORE_BCD_EN is defined.
module pingpong_score_enc
    import pingpong_pkg::*;
(
    input  logic [SCORE_W-1:0] score_i,
    output logic [SCORE_W-1:0] code_o
);

`ifdef SCORE_BCD_EN
    logic [SCORE_W-1:0] clip_s;
    logic [2:0]         tens_s;
    logic [3:0]         ones_s;

    // Three bits of tens are enough once the value is clipped to 79.
    always_comb begin
        if (score_i > 7'd79) begin
            clip_s = 7'd79;
        end else begin
            clip_s = score_i;
        end
        tens_s = 3'(clip_s / 7'd10);
        ones_s = 4'(clip_s % 7'd10);
        code_o = {tens_s, ones_s};
    end
`else
    // Binary build passes the score straight through.
    always_comb begin
        code_o = score_i;
    end
`endif

endmodule

// File: rtl/pingpong_score_ctrl.sv
// Ping-pong score keeper with serve tracking and Avalon-MM PIO score writes.
// Optional macro SCORE_BCD_EN selects BCD-encoded write data.
module pingpong_score_ctrl
    import pingpong_pkg::*;
#(
    parameter int WIN_POINTS = 11,
    parameter int WIN_MARGIN = 2,
    parameter int SERVE_SWAP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        point_a,
    input  logic        point_b,
    input  logic        new_game,
    output logic        pio_cs_a,
    output logic        pio_cs_b,
    output logic        pio_write_n,
    output logic [1:0]  pio_address,
    output logic [31:0] pio_writedata,
    output logic        server,
    output logic        game_over,
    output logic        winner,
    output logic        conflict
);

    localparam int CNT_W = (SERVE_SWAP > 1) ? $clog2(SERVE_SWAP) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_SWAP - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic               server_q, server_d, game_over_q, game_over_d;
    logic               winner_q, winner_d, conflict_q, conflict_d;
    logic               pend_a_q, pend_b_q;
    logic               chg_a_s, chg_b_s, deuce_s;
    logic               issue_a_s, issue_b_s;
    wr_state_e          state_q;
    logic [SCORE_W-1:0] enc_in_s, enc_out_s;

    // Next game state from the point inputs; saturation at the top score ends the game.
    always_comb begin
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        serve_cnt_d = serve_cnt_q;
        server_d    = server_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        chg_a_s     = 1'b0;
        chg_b_s     = 1'b0;
        deuce_s     = 1'b0;
        conflict_d  = !new_game && point_a && point_b;
        if (new_game) begin
            score_a_d   = {SCORE_W{1'b0}};
            score_b_d   = {SCORE_W{1'b0}};
            serve_cnt_d = {CNT_W{1'b0}};
            server_d    = PLAYER_A;
            game_over_d = 1'b0;
            winner_d    = PLAYER_A;
        end else if (!game_over_q && (point_a ^ point_b)) begin
            if (point_a) begin
                if (score_a_q == SCORE_MAX) begin
                    game_over_d = 1'b1;
                    winner_d    = PLAYER_A;
                end else begin
                    score_a_d = score_a_q + 7'd1;
                    chg_a_s   = 1'b1;
                end
            end else begin
                if (score_b_q == SCORE_MAX) begin
                    game_over_d = 1'b1;
                    winner_d    = PLAYER_B;
                end else begin
                    score_b_d = score_b_q + 7'd1;
                    chg_b_s   = 1'b1;
                end
            end
            deuce_s = (int'(score_a_d) >= WIN_POINTS - 1) && (int'(score_b_d) >= WIN_POINTS - 1);
            if (chg_a_s || chg_b_s) begin
                if (serve_cnt_q == CNT_LAST) begin
                    serve_cnt_d = {CNT_W{1'b0}};
                end else begin
                    serve_cnt_d = serve_cnt_q + CNT_W'(1);
                end
                if (deuce_s || (serve_cnt_q == CNT_LAST)) begin
                    server_d = ~server_q;
                end else begin
                    server_d = server_q;
                end
                if (has_won(score_a_d, score_b_d, WIN_POINTS, WIN_MARGIN)) begin
                    game_over_d = 1'b1;
                    winner_d    = PLAYER_A;
                end else if (has_won(score_b_d, score_a_d, WIN_POINTS, WIN_MARGIN)) begin
                    game_over_d = 1'b1;
                    winner_d    = PLAYER_B;
                end else begin
                    game_over_d = 1'b0;
                end
            end else begin
                serve_cnt_d = serve_cnt_q;
            end
        end else begin
            score_a_d = score_a_q;
        end
    end

    // Score state; a fresh score change wins over the clear from an issued write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_a_q   <= {SCORE_W{1'b0}};
            score_b_q   <= {SCORE_W{1'b0}};
            serve_cnt_q <= {CNT_W{1'b0}};
            server_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            conflict_q  <= 1'b0;
            pend_a_q    <= 1'b1;
            pend_b_q    <= 1'b1;
        end else begin
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            serve_cnt_q <= serve_cnt_d;
            server_q    <= server_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            conflict_q  <= conflict_d;
            if (new_game || chg_a_s) begin
                pend_a_q <= 1'b1;
            end else if (issue_a_s) begin
                pend_a_q <= 1'b0;
            end else begin
                pend_a_q <= pend_a_q;
            end
            if (new_game || chg_b_s) begin
                pend_b_q <= 1'b1;
            end else if (issue_b_s) begin
                pend_b_q <= 1'b0;
            end else begin
                pend_b_q <= pend_b_q;
            end
        end
    end

    // Which write starts at the next edge; A has priority only from IDLE.
    always_comb begin
        issue_a_s = 1'b0;
        issue_b_s = 1'b0;
        case (state_q)
            IDLE: begin
                issue_a_s = pend_a_q;
                issue_b_s = !pend_a_q && pend_b_q;
            end
            WR_A:    issue_b_s = pend_b_q;
            WR_B:    issue_a_s = pend_a_q;
            default: issue_a_s = 1'b0;
        endcase
        enc_in_s = issue_a_s ? score_a_q : score_b_q;
    end

    pingpong_score_enc u_enc (
        .score_i (enc_in_s),
        .code_o  (enc_out_s)
    );

    // Write FSM: every WR state is a single-cycle Avalon write with registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pio_cs_a      <= 1'b0;
            pio_cs_b      <= 1'b0;
            pio_write_n   <= 1'b1;
            pio_writedata <= 32'd0;
        end else if (issue_a_s) begin
            state_q       <= WR_A;
            pio_cs_a      <= 1'b1;
            pio_cs_b      <= 1'b0;
            pio_write_n   <= 1'b0;
            pio_writedata <= {{(32-SCORE_W){1'b0}}, enc_out_s};
        end else if (issue_b_s) begin
            state_q       <= WR_B;
            pio_cs_a      <= 1'b0;
            pio_cs_b      <= 1'b1;
            pio_write_n   <= 1'b0;
            pio_writedata <= {{(32-SCORE_W){1'b0}}, enc_out_s};
        end else begin
            state_q     <= IDLE;
            pio_cs_a    <= 1'b0;
            pio_cs_b    <= 1'b0;
            pio_write_n <= 1'b1;
        end
    end

    assign pio_address = 2'd0;
    assign server      = server_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign conflict    = conflict_q;

endmodule

// File: tb/tb_pingpong_score_ctrl.sv
// Directed self-checking bench for pingpong_score_ctrl (binary or SCORE_BCD_EN build).
module tb_pingpong_score_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        point_a = 1'b0;
    logic        point_b = 1'b0;
    logic        new_game = 1'b0;
    logic        pio_cs_a, pio_cs_b, pio_write_n;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;
    logic        server, game_over, winner, conflict;

    int n_checks = 0;
    int n_fails  = 0;
    int wa_cnt   = 0;
    int wb_cnt   = 0;
    logic [31:0] wa_data = 32'd0;
    logic [31:0] wb_data = 32'd0;
    int snap;

    pingpong_score_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .point_a       (point_a),
        .point_b       (point_b),
        .new_game      (new_game),
        .pio_cs_a      (pio_cs_a),
        .pio_cs_b      (pio_cs_b),
        .pio_write_n   (pio_write_n),
        .pio_address   (pio_address),
        .pio_writedata (pio_writedata),
        .server        (server),
        .game_over     (game_over),
        .winner        (winner),
        .conflict      (conflict)
    );

    always #5 clk = ~clk;

    // Write log: counts and last data per PIO, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && !pio_write_n) begin
            if (pio_cs_a) begin
                wa_cnt  = wa_cnt + 1;
                wa_data = pio_writedata;
            end
            if (pio_cs_b) begin
                wb_cnt  = wb_cnt + 1;
                wb_data = pio_writedata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_enc(input int v);
`ifdef SCORE_BCD_EN
        int c;
        c = (v > 79) ? 79 : v;
        return 32'(((c / 10) << 4) | (c % 10));
`else
        return 32'(v);
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One point pulse followed by enough idle cycles for its write to finish.
    task automatic point(input logic a, input logic b);
        point_a = a;
        point_b = b;
        tick();
        point_a = 1'b0;
        point_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic restart();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        tick();
        tick();
    endtask

    int server_exp[5] = '{0, 0, 1, 1, 0};

    initial begin
        // Reset values, then both PIOs rewritten with 0
        tick();
        tick();
        check("rst_cs_a", 32'(pio_cs_a), 32'd0);
        check("rst_cs_b", 32'(pio_cs_b), 32'd0);
        check("rst_write_n", 32'(pio_write_n), 32'd1);
        check("rst_wdata", pio_writedata, 32'd0);
        check("rst_addr", 32'(pio_address), 32'd0);
        check("rst_server", 32'(server), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_conflict", 32'(conflict), 32'd0);
        reset_n = 1'b1;
        tick();
        check("init_cs_a", {30'd0, pio_cs_a, pio_cs_b}, 32'd2);
        check("init_wr_a_n", 32'(pio_write_n), 32'd0);
        check("init_wdata_a", pio_writedata, 32'd0);
        tick();
        check("init_cs_b", {30'd0, pio_cs_a, pio_cs_b}, 32'd1);
        check("init_wdata_b", pio_writedata, 32'd0);
        tick();
        check("init_idle", {29'd0, pio_cs_a, pio_cs_b, pio_write_n}, 32'd1);

        // Five A points; server seen at each point and write latency of two edges
        for (int i = 0; i < 5; i++) begin
            check("serve_seq", 32'(server), 32'(server_exp[i]));
            point_a = 1'b1;
            tick();
            point_a = 1'b0;
            check("wr_lat_early", 32'(pio_cs_a), 32'd0);
            tick();
            check("wr_lat_cs_a", 32'(pio_cs_a), 32'd1);
            check("wr_lat_data", pio_writedata, exp_enc(i + 1));
            tick();
        end
        check("serve_after5", 32'(server), 32'd0);
        check("wa_count5", 32'(wa_cnt), 32'd6);

        // Deuce: 10-10 then A,B,A,A toggles server every point, A wins 13-11
        restart();
        for (int i = 0; i < 10; i++) begin
            point(1'b1, 1'b0);
            point(1'b0, 1'b1);
        end
        check("ten_a", wa_data, exp_enc(10));
        check("ten_b", wb_data, exp_enc(10));
        check("ten_server", 32'(server), 32'd0);
        point(1'b1, 1'b0);
        check("deuce_srv1", 32'(server), 32'd1);
        check("deuce_11_10", 32'(game_over), 32'd0);
        point(1'b0, 1'b1);
        check("deuce_srv2", 32'(server), 32'd0);
        point(1'b1, 1'b0);
        check("deuce_srv3", 32'(server), 32'd1);
        check("score_12", wa_data, exp_enc(12));
        check("deuce_12_11", 32'(game_over), 32'd0);
        point(1'b1, 1'b0);
        check("deuce_srv4", 32'(server), 32'd0);
        check("win_a_over", 32'(game_over), 32'd1);
        check("win_a_who", 32'(winner), 32'd0);
        check("score_13", wa_data, exp_enc(13));
        snap = wb_cnt;
        point(1'b0, 1'b1);
        check("over_no_wr", 32'(wb_cnt), 32'(snap));
        check("over_hold", 32'(game_over), 32'd1);

        // Simultaneous points: conflict pulse only
        restart();
        snap = wa_cnt + wb_cnt;
        point_a = 1'b1;
        point_b = 1'b1;
        tick();
        point_a = 1'b0;
        point_b = 1'b0;
        check("conflict_hi", 32'(conflict), 32'd1);
        tick();
        check("conflict_lo", 32'(conflict), 32'd0);
        tick();
        tick();
        check("conflict_no_wr", 32'(wa_cnt + wb_cnt), 32'(snap));
        check("conflict_srv", 32'(server), 32'd0);

        // Consecutive A then B from 0-0: back-to-back writes
        point_a = 1'b1;
        tick();
        point_a = 1'b0;
        point_b = 1'b1;
        tick();
        point_b = 1'b0;
        check("b2b_cs_a", {30'd0, pio_cs_a, pio_cs_b}, 32'd2);
        check("b2b_data_a", pio_writedata, exp_enc(1));
        tick();
        check("b2b_cs_b", {30'd0, pio_cs_a, pio_cs_b}, 32'd1);
        check("b2b_data_b", pio_writedata, exp_enc(1));
        tick();

        // new_game beats point_a in the same cycle
        new_game = 1'b1;
        point_a  = 1'b1;
        tick();
        new_game = 1'b0;
        point_a  = 1'b0;
        tick();
        check("ng_cs_a", {30'd0, pio_cs_a, pio_cs_b}, 32'd2);
        check("ng_data_a", pio_writedata, 32'd0);
        tick();
        check("ng_cs_b", {30'd0, pio_cs_a, pio_cs_b}, 32'd1);
        check("ng_data_b", pio_writedata, 32'd0);
        tick();

        // Long deuce up to saturation at 127: A declared winner
        restart();
        for (int i = 0; i < 126; i++) begin
            point(1'b1, 1'b0);
            point(1'b0, 1'b1);
        end
        point(1'b1, 1'b0);
        check("sat_127_open", 32'(game_over), 32'd0);
        check("sat_127_data", wa_data, exp_enc(127));
        snap = wa_cnt;
        point(1'b1, 1'b0);
        check("sat_over", 32'(game_over), 32'd1);
        check("sat_winner", 32'(winner), 32'd0);
        check("sat_no_wr", 32'(wa_cnt), 32'(snap));

        // B wins 11-0, then reset lands in the middle of the final WR_B
        restart();
        for (int i = 0; i < 10; i++) begin
            point(1'b0, 1'b1);
        end
        check("b_ten_open", 32'(game_over), 32'd0);
        point_b = 1'b1;
        tick();
        point_b = 1'b0;
        check("win_b_over", 32'(game_over), 32'd1);
        check("win_b_who", 32'(winner), 32'd1);
        check("win_b_srv", 32'(server), 32'd1);
        tick();
        check("mid_cs_b", 32'(pio_cs_b), 32'd1);
        check("mid_data", pio_writedata, exp_enc(11));
        reset_n = 1'b0;
        #1;
        check("arst_cs_b", 32'(pio_cs_b), 32'd0);
        check("arst_write_n", 32'(pio_write_n), 32'd1);
        check("arst_wdata", pio_writedata, 32'd0);
        check("arst_over", 32'(game_over), 32'd0);
        check("arst_winner", 32'(winner), 32'd0);
        check("arst_server", 32'(server), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rerst_cs_a", {30'd0, pio_cs_a, pio_cs_b}, 32'd2);
        check("rerst_data", pio_writedata, 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
